// File: rtl/drum_pkg.sv
// drum_pkg -- shared constants and types for the DRUM dot-product accumulator.
//
// Contents:
//   PW_DEF  : default product width (n+m of the DRUM multiplier)
//   AW_DEF  : default accumulator width (multiple of 8, >= PW)
//   state_t : accumulator FSM state (ACCUM collects terms, DRAIN emits bytes)
package drum_pkg;

    localparam int PW_DEF = 8;
    localparam int AW_DEF = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/drum_acc_ser.sv
// drum_acc_ser -- byte serialiser for the accumulator result register.
//
// Presents the AW-bit result least-significant byte first. The byte index
// advances only when a byte is accepted and wraps to 0 after the last byte.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset (index -> 0)
//   result     in   AW    result register being drained
//   active     in   1     high while a result is offered (out_valid)
//   out_ready  in   1     consumer acceptance
//   out_data   out  8     currently selected result byte
//   last_byte  out  1     high when the selected byte is the final one
module drum_acc_ser
    import drum_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] result,
    input  logic          active,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          last_byte
);

    localparam int NB = AW / 8;
    // Keep the index at least one bit wide so AW == 8 still elaborates.
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0] idx;
    logic [AW-1:0] shifted;

    assign shifted   = result >> (32'(idx) * 8);
    assign out_data  = shifted[7:0];
    assign last_byte = (idx == IW'(NB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (active && out_ready) begin
            if (last_byte) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/drum_acc.sv
// drum_acc -- signed dot-product accumulator behind a DRUM multiplier.
//
// Terms (signed PW-bit products) are sign-extended and summed in an AW-bit
// signed accumulator. A term flagged in_last closes the dot product: the
// sum and its sticky overflow flag move to the result register and the
// result is drained one byte per accepted beat, LSB first.
//
// Build option:
//   DRUM_ACC_SAT_EN  defined   -> an overflowing add clamps to the signed
//                                 limit matching the sign of the true sum
//                    undefined -> the accumulator wraps modulo 2^AW
//   The overflow flag behaves the same either way.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_prod    in   PW    signed product term
//   in_valid   in   1     qualifies in_prod
//   in_last    in   1     marks the final term of a dot product
//   in_ready   out  1     a term can be accepted (ACCUM state)
//   out_data   out  8     result byte currently offered
//   out_ovf    out  1     sticky overflow of the offered result
//   out_valid  out  1     qualifies out_data / out_ovf (DRAIN state)
//   out_ready  in   1     consumer acceptance
module drum_acc
    import drum_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] in_prod,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_ovf,
    output logic          out_valid,
    input  logic          out_ready
);

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic signed [AW-1:0] a,
                                     input logic signed [AW-1:0] b,
                                     input logic signed [AW-1:0] s);
        return (a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]);
    endfunction

`ifdef DRUM_ACC_SAT_EN
    // On overflow the true sum carries the operands' common sign.
    function automatic logic signed [AW-1:0] sat_clamp(input logic signed [AW-1:0] s,
                                                       input logic               o,
                                                       input logic               neg);
        if (!o) begin
            return s;
        end else if (neg) begin
            return {1'b1, {(AW-1){1'b0}}};
        end else begin
            return {1'b0, {(AW-1){1'b1}}};
        end
    endfunction
`endif

    state_t               state;
    logic signed [AW-1:0] acc;
    logic                 ovf;
    logic signed [AW-1:0] result;
    logic                 result_ovf;
    logic                 last_byte;

    logic signed [PW-1:0] prod_s;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] sum_raw;
    logic                 sum_ovf;
    logic signed [AW-1:0] acc_next;

    assign prod_s  = in_prod;
    assign term    = AW'(prod_s);
    assign sum_raw = acc + term;
    assign sum_ovf = add_ovf(acc, term, sum_raw);

`ifdef DRUM_ACC_SAT_EN
    assign acc_next = sat_clamp(sum_raw, sum_ovf, acc[AW-1]);
`else
    assign acc_next = sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            ovf        <= 1'b0;
            result     <= '0;
            result_ovf <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (in_last) begin
                            result     <= acc_next;
                            result_ovf <= ovf | sum_ovf;
                            acc        <= '0;
                            ovf        <= 1'b0;
                            state      <= DRAIN;
                        end else begin
                            acc <= acc_next;
                            ovf <= ovf | sum_ovf;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready && last_byte) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign out_ovf   = result_ovf;

    drum_acc_ser #(
        .AW(AW)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .active   (out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .last_byte(last_byte)
    );

endmodule

// File: tb/tb_drum_acc.sv
// tb_drum_acc -- self-checking bench for drum_acc (default PW=8, AW=16).
// A behavioural model sums terms with integer arithmetic, predicts the
// byte stream, and is compared against the DUT every cycle; directed
// sequences additionally compare captured bytes with literal values.
module tb_drum_acc;

    localparam int PW = 8;
    localparam int AW = 16;
    localparam int NB = AW / 8;
    localparam int SMAX = (1 << (AW - 1)) - 1;
    localparam int SMIN = -(1 << (AW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] in_prod = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready = 1'b0;

    drum_acc #(.PW(PW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_prod  (in_prod),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Model state
    typedef struct {
        logic [7:0] b;
        logic       o;
    } exp_t;
    exp_t       exp_q[$];
    int         m_acc = 0;
    bit         m_ovf = 0;
    logic [7:0] got_q[$];
    logic       got_ovf_q[$];
    bit         post_rst = 0;
    bit         prev_ov = 0;
    int         bytes_seen = 0;

    task automatic model_accept(input logic [PW-1:0] p, input logic last);
        int         s;
        logic [31:0] r;
        exp_t       e;
        s = m_acc + int'($signed(p));
        if (s > SMAX || s < SMIN) begin
            m_ovf = 1;
`ifdef DRUM_ACC_SAT_EN
            s = (s > SMAX) ? SMAX : SMIN;
`else
            s = ((s - SMIN + (1 << AW)) % (1 << AW)) + SMIN;
`endif
        end
        m_acc = s;
        if (last) begin
            r = s;
            for (int k = 0; k < NB; k++) begin
                e.b = r[7:0];
                e.o = m_ovf;
                exp_q.push_back(e);
                r = r >> 8;
            end
            m_acc = 0;
            m_ovf = 0;
        end
    endtask

    // Compare process: inputs are driven 1 time unit after posedge, so at
    // the negedge both sides of every handshake are stable.
    always @(negedge clk) begin
        bit m_valid;
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
            m_ovf = 0;
            post_rst = 1;
            prev_ov = 0;
            bytes_seen = 0;
        end else begin
            if (post_rst) begin
                check("rst_out_data", 32'(out_data), 32'h00);
                check("rst_out_ovf", 32'(out_ovf), 32'h0);
                post_rst = 0;
            end
            m_valid = (exp_q.size() != 0);
            check("in_ready", 32'(in_ready), 32'(!m_valid));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (prev_ov && !out_valid) begin
                check("bytes_per_result", 32'(bytes_seen), 32'(NB));
                bytes_seen = 0;
            end
            prev_ov = out_valid;
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].b));
                check("out_ovf", 32'(out_ovf), 32'(exp_q[0].o));
                if (out_ready) begin
                    got_q.push_back(out_data);
                    got_ovf_q.push_back(out_ovf);
                    void'(exp_q.pop_front());
                    bytes_seen++;
                end
            end else if (in_valid) begin
                model_accept(in_prod, in_last);
            end
        end
    end

    task automatic send(input logic [7:0] p, input logic last);
        bit a;
        int n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        do begin
            a = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 200);
        if (!a) check("send_timeout", 32'(n), 32'(0));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_got2(input string name, input logic [7:0] b0, input logic [7:0] b1,
                              input logic o);
        check({name, "_count"}, 32'(got_q.size()), 32'(2));
        if (got_q.size() == 2) begin
            check({name, "_b0"}, 32'(got_q[0]), 32'(b0));
            check({name, "_b1"}, 32'(got_q[1]), 32'(b1));
            check({name, "_ovf0"}, 32'(got_ovf_q[0]), 32'(o));
            check({name, "_ovf1"}, 32'(got_ovf_q[1]), 32'(o));
        end
        got_q.delete();
        got_ovf_q.delete();
    endtask

    initial begin
        logic [7:0] b2b_exp [6];
        b2b_exp = '{8'h30, 8'h00, 8'hF0, 8'hFF, 8'h7D, 8'h01};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 5 + (-3) = 2
        out_ready = 1'b1;
        send(8'h05, 1'b0);
        send(8'hFD, 1'b1);
        wait_idle();
        check_got2("basic", 8'h02, 8'h00, 1'b0);

        // single term -128 -> 0xFF80
        send(8'h80, 1'b1);
        wait_idle();
        check_got2("single", 8'h80, 8'hFF, 1'b0);

        // 300 * 127 = 38100 overflows 16-bit signed
        for (int i = 0; i < 300; i++) send(8'h7F, (i == 299));
        wait_idle();
`ifdef DRUM_ACC_SAT_EN
        check_got2("ovf300", 8'hFF, 8'h7F, 1'b1);
`else
        check_got2("ovf300", 8'hD4, 8'h94, 1'b1);
`endif

        // stall in DRAIN while terms are presented
        out_ready = 1'b0;
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_prod  = 8'h55;
            in_last  = i[0];
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check_got2("stall", 8'h07, 8'h00, 1'b0);
        send(8'h02, 1'b1);
        wait_idle();
        check_got2("after_stall", 8'h02, 8'h00, 1'b0);

        // reset after the first drained byte
        out_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_first_byte_count", 32'(got_q.size()), 32'(1));
        if (got_q.size() == 1) check("midrst_first_byte", 32'(got_q[0]), 32'h46);
        got_q.delete();
        got_ovf_q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h01, 1'b1);
        wait_idle();
        check_got2("post_rst", 8'h01, 8'h00, 1'b0);

        // back-to-back dot products
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h7F, 1'b0);
        send(8'h7F, 1'b0);
        send(8'h7F, 1'b1);
        wait_idle();
        check("b2b_count", 32'(got_q.size()), 32'(6));
        if (got_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("b2b_byte", 32'(got_q[i]), 32'(b2b_exp[i]));
        end
        got_q.delete();
        got_ovf_q.delete();

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drum_acc.md
DRUM_ACC -- requirements
Module: drum_acc

Interface
REQ-001 The parameter PW SHALL default to 8 and SHALL set the product width, equal to n+m of the DRUM multiplier feeding this block.
REQ-002 The parameter AW SHALL default to 16 and SHALL set the accumulator width; AW SHALL be a multiple of 8 and at least PW.
REQ-003 `clk  in  1` SHALL be the single clock; all state updates on its rising edge.
REQ-004 `rst  in  1` SHALL be a synchronous, active-high reset.
REQ-005 `in_prod  in  PW` SHALL carry a signed two's-complement product from the DRUM multiplier.
REQ-006 `in_valid  in  1` SHALL qualify in_prod.
REQ-007 `in_last  in  1` SHALL mark the final term of a dot product.
REQ-008 `in_ready  out  1` SHALL indicate that a term can be accepted.
REQ-009 `out_data  out  8` SHALL carry the result byte currently offered.
REQ-010 `out_ovf  out  1` SHALL be the sticky overflow flag of the offered result.
REQ-011 `out_valid  out  1` SHALL qualify out_data and out_ovf.
REQ-012 `out_ready  in  1` SHALL be the consumer acceptance signal.

Function
REQ-013 A term SHALL be accepted on a cycle where in_valid and in_ready are both high; a byte SHALL be accepted on a cycle where out_valid and out_ready are both high.
REQ-014 The FSM SHALL have two states: ACCUM, where in_ready=1 and out_valid=0, and DRAIN, where in_ready=0 and out_valid=1.
REQ-015 In ACCUM, an accepted term SHALL update acc <= acc + sext(in_prod) using AW-bit signed arithmetic.
REQ-016 Signed overflow of that AW-bit add SHALL set the sticky ovf bit.
REQ-017 An accepted term with in_last=1 SHALL load the final sum and ovf into the result register, clear acc and ovf, and move the FSM to DRAIN.
REQ-018 out_valid SHALL rise in the cycle after the in_last term is accepted, giving a latency of 1 cycle.
REQ-019 In DRAIN, out_data SHALL present result bytes least-significant byte first, with byte index 0..AW/8-1.
REQ-020 The byte index SHALL advance only on an accepted byte.
REQ-021 Acceptance of byte AW/8-1 SHALL return the FSM to ACCUM on the next cycle and reset the byte index to 0.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_ovf SHALL hold stable.
REQ-023 out_ovf SHALL equal the ovf of the result being drained, for every byte of that result.
REQ-024 Terms presented while the FSM is in DRAIN SHALL NOT be accepted, and acc SHALL be unchanged.
REQ-025 A single-term dot product (in_last on the first beat) SHALL yield sext(in_prod).
REQ-026 An in_valid=0 cycle SHALL leave acc unchanged.

Reset
REQ-027 Reset SHALL force the FSM to ACCUM, acc=0, ovf=0, byte index=0, and the result register to 0.
REQ-028 Outputs after reset SHALL be in_ready=1, out_valid=0, out_data=0x00 and out_ovf=0, effective on the cycle after rst is sampled high.
REQ-029 Reset asserted mid-accumulation or mid-drain SHALL discard the partial sum or the undelivered bytes with no further output.

Configuration
REQ-030 When DRUM_ACC_SAT_EN is defined, an overflowing add SHALL clamp acc to +2^(AW-1)-1 or -2^(AW-1), chosen by the sign of the true sum, and later terms SHALL add to the clamped value.
REQ-031 When DRUM_ACC_SAT_EN is undefined, acc SHALL wrap modulo 2^AW.
REQ-032 The ovf flag SHALL be set identically whether or not DRUM_ACC_SAT_EN is defined.

Structure
REQ-033 The shared package drum_pkg SHALL hold the PW/AW default constants and the FSM state typedef (ACCUM, DRAIN).
REQ-034 Byte selection and index counting SHALL reside in one sub-module, drum_acc_ser, which takes the AW-bit result register plus the handshake and returns out_data and the last-byte indication.

Verification
REQ-035 The bench SHALL drive terms 0x05, 0xFD (last) and check output bytes 0x02, 0x00 with out_ovf=0 and out_valid rising 1 cycle after the last accept.
REQ-036 The bench SHALL drive a single term 0x80 with last set and check bytes 0x80, 0xFF.
REQ-037 The bench SHALL drive 300 terms of 0x7F and check bytes FF, 7F with ovf=1 when DRUM_ACC_SAT_EN is defined, and bytes D4, 94 with ovf=1 when it is undefined.
REQ-038 The bench SHALL hold out_ready low for 5 cycles in DRAIN and check that out_data and out_ovf are stable, in_ready=0, and that in_valid pulses leave the next dot product unaffected.
REQ-039 The bench SHALL assert rst after the first byte of a drain and check out_valid=0 and in_ready=1 on the next cycle, and that a following 0x01 (last) yields 0x01, 0x00.
REQ-040 The bench SHALL run back-to-back dot products with out_ready held high and check exactly AW/8 bytes per result and no lost or duplicated terms.
